// File: rtl/apb_pkg.sv
// Shared definitions for the APB master: FSM state type and parameter defaults.
package apb_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_master.sv
// APB master: converts one valid/ready command into a single APB transfer
// and returns the result on a valid/ready response channel. An ACCESS phase
// that sees no pready for TIMEOUT cycles is aborted with rsp_err=1.
//
// Ports:
//   pclk, prst                   clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata   command channel
//   rsp_valid/ready/rdata/err          response channel
//   psel, pen, pwrite, paddr, pwdata   APB request outputs
//   pready, prdata                     APB completion inputs
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              pen,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  // One extra count value so the counter can step past TIMEOUT-1 on abort.
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  apb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d;
  logic [DATA_W-1:0] rdata_d;
  logic              err_d;
  logic              psel_d, pen_d, cmd_ready_d, rsp_valid_d;

  // Next-state, captured-command and response computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pwrite_d = pwrite;
    paddr_d  = paddr;
    pwdata_d = pwdata;
    rdata_d  = rsp_rdata;
    err_d    = rsp_err;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // pready takes priority over the timeout in the same cycle.
        if (pready) begin
          rdata_d = pwrite ? DATA_W'(0) : prdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            rdata_d = DATA_W'(0);
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    pen_d       = (state_d == ACCESS);
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // State and output registers.
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= 1'b0;
      pen       <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      rsp_rdata <= rdata_d;
      rsp_err   <= err_d;
      psel      <= psel_d;
      pen       <= pen_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
    end
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 8, APB address width.
REQ-002 Parameter DATA_W, default 8, APB data width.
REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS cycles without pready before abort; legal range 1..255.
REQ-004 pclk  input  1  single clock; all flops on rising edge.
REQ-005 prst  input  1  reset; asynchronous assert, active-low; one clock, no other reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at rising pclk.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_W  transfer address.
REQ-010 cmd_wdata  input  DATA_W  write data.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-013 rsp_rdata  output  DATA_W  read data; 0 for writes and aborted transfers.
REQ-014 rsp_err  output  1  1 = transfer aborted by timeout.
REQ-015 psel, pen, pwrite  output  1 each  APB control.
REQ-016 paddr  output  ADDR_W; pwdata  output  DATA_W  APB address and write data.
REQ-017 pready  input  1; prdata  input  DATA_W  APB completion and read data.

Function
REQ-018 FSM states: IDLE, SETUP, ACCESS, RESP.
REQ-019 IDLE: cmd_ready=1. A handshake captures cmd_write/addr/wdata; the next state is SETUP.
REQ-020 cmd_ready is 0 in SETUP, ACCESS and RESP; cmd_valid in those states is ignored and not buffered.
REQ-021 SETUP (exactly 1 cycle): psel=1, pen=0, with paddr/pwdata/pwrite driven from captured values; the next state is ACCESS.
REQ-022 ACCESS: psel=1, pen=1, all APB outputs stable; stay in ACCESS while pready=0.
REQ-023 ACCESS with pready=1: for a read, rsp_rdata<=prdata, otherwise 0; rsp_err<=0; the next state is RESP.
REQ-024 Wait counter: cleared on entry to ACCESS and incremented each ACCESS cycle with pready=0.
REQ-025 When the counter reaches TIMEOUT-1 and pready=0, the transfer aborts: rsp_err<=1, rsp_rdata<=0, next state RESP.
REQ-026 If pready=1 in the same cycle as the timeout condition, pready wins and rsp_err=0.
REQ-027 pready and prdata are ignored outside ACCESS.
REQ-028 RESP: psel=0, pen=0, rsp_valid=1; rsp_rdata and rsp_err are held stable until the handshake.
REQ-029 A RESP handshake returns the FSM to IDLE; with rsp_ready already high, RESP lasts 1 cycle.
REQ-030 In IDLE and RESP, psel=0 and pen=0; paddr, pwdata and pwrite keep their last values.
REQ-031 Latency, zero wait states: accept at edge N, SETUP in cycle N+1, ACCESS in N+2, rsp_valid in N+3.
REQ-032 Each added wait state adds 1 cycle.
REQ-033 Throughput: at most one transfer in flight; a new command is accepted no earlier than the cycle after the RESP handshake.
REQ-034 All APB and rsp outputs are driven from flops or pure state decode; there are no combinational paths from pready to psel or pen.

Reset
REQ-035 prst low forces IDLE asynchronously, whatever the current state, including mid-SETUP or mid-ACCESS.
REQ-036 Reset values: psel=0, pen=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0.
REQ-037 While prst is low no handshake takes effect; the first acceptance is possible at the first rising pclk after release.

Structure
REQ-038 Shared package apb_pkg holds: the state enum type (IDLE, SETUP, ACCESS, RESP), ADDR_W/DATA_W defaults, and the TIMEOUT default.
REQ-039 Single module, no sub-module; the wait counter is inline, width $clog2(TIMEOUT+1).

Verification
REQ-040 Write, zero wait: cmd addr=0x10, wdata=0xA5 -> psel at N+1, pen at N+2, pwrite=1 and pwdata=0xA5 stable, rsp_valid at N+3 with rsp_err=0.
REQ-041 Read, 3 wait states: slave returns prdata=0x3C with pready on the 4th ACCESS cycle -> rsp_rdata=0x3C, rsp_valid at N+6.
REQ-042 Timeout: TIMEOUT=4, pready held 0 -> exactly 4 ACCESS cycles, then rsp_err=1, rsp_rdata=0, psel=pen=0.
REQ-043 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and data stable, cmd_ready=0 throughout, cmd_valid pulses ignored; IDLE after the handshake.
REQ-044 Reset mid-ACCESS: prst low during a wait state -> psel, pen and rsp_valid go 0 immediately without waiting for pclk; first new command after release completes normally.
REQ-045 Tie-break: pready=1 on the final timeout cycle -> rsp_err=0 and rsp_rdata=prdata.
